tetromino_bag_scheduler: RTL and testbench

- Sits between the LFSR tetromino generator and the game FSM.
- Steps the generator and filters its raw 0..6 piece index through a 7-bag rule: each type appears exactly once per bag of 7.
- Keeps a preview queue of upcoming pieces and hands pieces to the game FSM over a valid/ready handshake.
- A forced-pick fallback bounds the time needed to finish a bag.

---
 rtl/tetromino_bag_scheduler.sv | 167 ++++++++++++++++
 tb/tb_tetromino_bag_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tetromino_bag_scheduler.sv
// tetromino_bag_scheduler: 7-bag filter and preview queue between the LFSR
// tetromino generator and the game FSM.
// Optional hold slot is compiled in when TETRIS_HOLD_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FILL  | queue has a free entry; generator stepped and drawn each cycle
// S_FULL  | queue holds DEPTH entries; generator idle, retry count held
module tetromino_bag_scheduler #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     gen_enable,
    input  logic [2:0]               gen_idx,
    output logic                     piece_valid,
    input  logic                     piece_ready,
    output logic [2:0]               piece_idx,
    output logic [3*(DEPTH-1)-1:0]   preview_idx,
    output logic [3:0]               preview_count,
    output logic [6:0]               bag_mask
`ifdef TETRIS_HOLD_EN
    ,
    input  logic                     hold_req,
    input  logic [2:0]               active_idx,
    output logic                     hold_done,
    output logic [2:0]               hold_out_idx,
    output logic                     hold_valid
`endif
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t          state, state_nxt;
    logic [2:0]      q [DEPTH];
    logic [3:0]      count;
    logic [RW-1:0]   retry, retry_nxt;
    logic            push, pop, piece_pop, hold_pop;
    logic [2:0]      push_idx, free_idx;
    logic [3:0]      push_pos;
    logic [7:0]      mask_ext;
    logic [6:0]      mask_set;

    // gen_idx 7 indexes the padding bit, so it always reads as already drawn
    assign mask_ext  = {1'b1, bag_mask};
    assign piece_pop = piece_valid && piece_ready;
    assign pop       = piece_pop || hold_pop;
    assign push_pos  = pop ? (count - 4'd1) : count;
    assign mask_set  = bag_mask | (7'd1 << push_idx);

    // Lowest-numbered type not yet drawn in this bag, used by the forced pick
    always_comb begin
        free_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!bag_mask[i]) free_idx = 3'(i);
        end
    end

    // Next-state, draw accept/reject and retry bookkeeping
    always_comb begin
        state_nxt  = state;
        gen_enable = 1'b0;
        push       = 1'b0;
        push_idx   = gen_idx;
        retry_nxt  = retry;
        case (state)
            S_FILL: begin
                gen_enable = reset_n;
                if (!mask_ext[gen_idx]) begin
                    push      = 1'b1;
                    retry_nxt = '0;
                end else if (retry == RETRY_LAST) begin
                    push      = 1'b1;
                    push_idx  = free_idx;
                    retry_nxt = '0;
                end else begin
                    retry_nxt = retry + 1'b1;
                end
                if (push && !pop && (count == 4'(DEPTH - 1))) state_nxt = S_FULL;
            end
            S_FULL: begin
                if (pop) state_nxt = S_FILL;
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // State, retry counter and bag mask registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FILL;
            retry    <= '0;
            bag_mask <= '0;
        end else begin
            state <= state_nxt;
            retry <= retry_nxt;
            if (push) bag_mask <= (mask_set == 7'h7F) ? 7'h00 : mask_set;
        end
    end

    // Queue storage: shift on pop, write the new draw behind the last valid entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= 3'd0;
            count <= 4'd0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
                q[DEPTH-1] <= 3'd0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (4'(i) == push_pos)) q[i] <= push_idx;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Entries past count are kept at zero by the shift, so outputs read them directly
    always_comb begin
        piece_valid   = (count != 4'd0);
        piece_idx     = q[0];
        preview_count = count;
        preview_idx   = '0;
        for (int i = 1; i < DEPTH; i++) preview_idx[3*(i-1) +: 3] = q[i];
    end

`ifdef TETRIS_HOLD_EN
    logic       hold_accept, hold_lock;
    logic [2:0] hold_slot;

    // An empty slot needs a queue head to take, so the request stalls on an empty queue
    assign hold_accept = hold_req && !hold_lock && (hold_valid || piece_valid);
    assign hold_pop    = hold_accept && !hold_valid;

    // Hold slot, lock and done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_slot    <= 3'd0;
            hold_valid   <= 1'b0;
            hold_lock    <= 1'b0;
            hold_done    <= 1'b0;
            hold_out_idx <= 3'd0;
        end else begin
            hold_done <= hold_accept;
            if (hold_accept) begin
                hold_out_idx <= hold_valid ? hold_slot : q[0];
                hold_slot    <= active_idx;
                hold_valid   <= 1'b1;
                hold_lock    <= 1'b1;
            end else if (piece_pop) begin
                hold_lock <= 1'b0;
            end
        end
    end
`else
    assign hold_pop = 1'b0;
`endif

endmodule

// File: tb/tb_tetromino_bag_scheduler.sv
// Self-checking bench for tetromino_bag_scheduler (default build, no hold slot).
// A queue-based model of the 7-bag rule predicts every output each cycle.
module tb_tetromino_bag_scheduler;

    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 8;
    localparam int PW        = 3 * (DEPTH - 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          gen_enable;
    logic [2:0]    gen_idx = 3'd0;
    logic          piece_valid;
    logic          piece_ready = 1'b0;
    logic [2:0]    piece_idx;
    logic [PW-1:0] preview_idx;
    logic [3:0]    preview_count;
    logic [6:0]    bag_mask;

    int total = 0;
    int bad   = 0;

    int mq[$];
    bit used[7];
    int retry;

    tetromino_bag_scheduler #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .gen_enable(gen_enable),
        .gen_idx(gen_idx),
        .piece_valid(piece_valid),
        .piece_ready(piece_ready),
        .piece_idx(piece_idx),
        .preview_idx(preview_idx),
        .preview_count(preview_count),
        .bag_mask(bag_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        foreach (used[k]) used[k] = 1'b0;
        retry = 0;
    endfunction

    function automatic void model_step(input int idx, input bit rdy);
        bit full = (mq.size() == DEPTH);
        bit pop  = (mq.size() != 0) && rdy;
        int pushv = -1;
        bit all;
        if (!full) begin
            if (idx <= 6 && !used[idx]) begin
                pushv = idx;
                retry = 0;
            end else begin
                retry++;
                if (retry == MAX_RETRY) begin
                    for (int k = 6; k >= 0; k--) if (!used[k]) pushv = k;
                    retry = 0;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (pushv >= 0) begin
            mq.push_back(pushv);
            used[pushv] = 1'b1;
            all = 1'b1;
            foreach (used[k]) all &= used[k];
            if (all) foreach (used[k]) used[k] = 1'b0;
        end
    endfunction

    task automatic check_model(input string tag);
        logic [PW-1:0] ep;
        logic [6:0]    em;
        ep = '0;
        for (int i = 1; i < DEPTH; i++) if (i < mq.size()) ep[3*(i-1) +: 3] = 3'(mq[i]);
        em = '0;
        for (int k = 0; k < 7; k++) em[k] = used[k];
        chk({tag, ".gen_enable"}, 16'(gen_enable), 16'(mq.size() < DEPTH));
        chk({tag, ".valid"}, 16'(piece_valid), 16'(mq.size() != 0));
        chk({tag, ".piece_idx"}, 16'(piece_idx), (mq.size() != 0) ? 16'(mq[0]) : 16'd0);
        chk({tag, ".preview"}, 16'(preview_idx), 16'(ep));
        chk({tag, ".count"}, 16'(preview_count), 16'(mq.size()));
        chk({tag, ".mask"}, 16'(bag_mask), 16'(em));
    endtask

    // Called at a falling edge: drive, check against model, advance model, wait a cycle.
    task automatic step(input logic [2:0] idx, input logic rdy, input string tag);
        gen_idx     = idx;
        piece_ready = rdy;
        #1;
        check_model(tag);
        model_step(int'(idx), rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        piece_ready = 1'b0;
        gen_idx     = 3'd0;
        #1;
        chk("rst.count", 16'(preview_count), 16'd0);
        chk("rst.valid", 16'(piece_valid), 16'd0);
        chk("rst.piece_idx", 16'(piece_idx), 16'd0);
        chk("rst.preview", 16'(preview_idx), 16'd0);
        chk("rst.mask", 16'(bag_mask), 16'd0);
        chk("rst.gen_enable", 16'(gen_enable), 16'd0);
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] last;
        model_reset();
        @(negedge clk);

        // Fill with 0..3, nothing consumed
        do_reset();
        step(3'd0, 1'b0, "fill0");
        chk("latency.valid", 16'(piece_valid), 16'd1);
        step(3'd1, 1'b0, "fill1");
        step(3'd2, 1'b0, "fill2");
        step(3'd3, 1'b0, "fill3");
        chk("fill.count", 16'(preview_count), 16'd4);
        chk("fill.head", 16'(piece_idx), 16'd0);
        chk("fill.preview", 16'(preview_idx), 16'(9'b011_010_001));
        chk("fill.gen_enable", 16'(gen_enable), 16'd0);

        // Full queue, one pop while a legal refill draw is waiting: 4 -> 3 -> 4
        step(3'd4, 1'b1, "refill_pop");
        chk("refill.count3", 16'(preview_count), 16'd3);
        chk("refill.head1", 16'(piece_idx), 16'd1);
        step(3'd4, 1'b0, "refill_push");
        chk("refill.count4", 16'(preview_count), 16'd4);
        chk("refill.preview", 16'(preview_idx), 16'(9'b100_011_010));

        // Whole bag in order with consumer always ready, then bag wraps
        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(3'(k), 1'b1, "bag");
            chk("bag.seq", 16'(piece_idx), 16'(k));
        end
        chk("bag.wrap_mask", 16'(bag_mask), 16'd0);
        step(3'd0, 1'b1, "bag_next");
        chk("bag.next_valid", 16'(piece_valid), 16'd1);
        chk("bag.next_idx", 16'(piece_idx), 16'd0);

        // Index 7 is always rejected
        do_reset();
        step(3'd7, 1'b0, "idx7");
        chk("idx7.count", 16'(preview_count), 16'd0);
        chk("idx7.mask", 16'(bag_mask), 16'd0);

        // Repeated draw of 3 forces index 0 on the 8th reject, then 1 eight rejects later
        do_reset();
        step(3'd3, 1'b0, "retry_first");
        for (int k = 0; k < MAX_RETRY - 1; k++) begin
            step(3'd3, 1'b0, "retry_rej");
            chk("retry.no_push", 16'(preview_count), 16'd1);
        end
        step(3'd3, 1'b0, "retry_force");
        chk("force.count", 16'(preview_count), 16'd2);
        chk("force.idx", 16'(preview_idx[2:0]), 16'd0);
        chk("force.mask", 16'(bag_mask), 16'(7'b0001001));
        for (int k = 0; k < MAX_RETRY - 1; k++) step(3'd3, 1'b0, "retry_rej2");
        chk("retry.cleared", 16'(preview_count), 16'd2);
        step(3'd3, 1'b0, "retry_force2");
        chk("force2.idx", 16'(preview_idx[5:3]), 16'd1);

        // Reset mid-handshake discards everything immediately
        piece_ready = 1'b1;
        reset_n     = 1'b0;
        #1;
        chk("midrst.count", 16'(preview_count), 16'd0);
        chk("midrst.mask", 16'(bag_mask), 16'd0);
        @(negedge clk);
        do_reset();

        // Randomized draws and consumer, with runs of repeated indices to reach forced picks
        last = 3'd0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) < 4) gen_idx = last;
            else gen_idx = 3'($urandom_range(0, 7));
            last = gen_idx;
            step(gen_idx, 1'($urandom_range(0, 1)), "rand");
        end
        #1;
        check_model("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
